// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester sequencer and round-robin arbiter for one
// shared 8-bit ALU (fwd/add/and/or).
//
// Ports:
//   CLK, RESET            clock (posedge), synchronous active-high reset
//   REQn_VALID/READY      per-requester valid/ready handshake (n = 0, 1)
//   REQn_DATA1/DATA2      operands, REQn_SELECT op code
//   RESPn_VALID/RESULT    one-cycle response pulse and held result
//   ALU_DATA1/2, SELECT   registered drive to the external ALU
//   ALU_RESULT            ALU output, sampled after EXEC_CYCLES cycles
//   BUSY                  high in EXEC or RESP
//   RESPn_ZERO            zero flag, only with ALU_ARB_ZERO_FLAG_EN defined
//
// Optional feature macro: ALU_ARB_ZERO_FLAG_EN
module alu_arbiter #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       REQ0_VALID,
    output logic       REQ0_READY,
    input  logic [7:0] REQ0_DATA1,
    input  logic [7:0] REQ0_DATA2,
    input  logic [2:0] REQ0_SELECT,
    output logic       RESP0_VALID,
    output logic [7:0] RESP0_RESULT,
    input  logic       REQ1_VALID,
    output logic       REQ1_READY,
    input  logic [7:0] REQ1_DATA1,
    input  logic [7:0] REQ1_DATA2,
    input  logic [2:0] REQ1_SELECT,
    output logic       RESP1_VALID,
    output logic [7:0] RESP1_RESULT,
    output logic [7:0] ALU_DATA1,
    output logic [7:0] ALU_DATA2,
    output logic [2:0] ALU_SELECT,
    input  logic [7:0] ALU_RESULT,
`ifdef ALU_ARB_ZERO_FLAG_EN
    output logic       RESP0_ZERO,
    output logic       RESP1_ZERO,
`endif
    output logic       BUSY
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          gnt;
    logic          last_grant;
    logic          rsvd;

    logic          acc_id;
    logic [7:0]    acc_d1;
    logic [7:0]    acc_d2;
    logic [2:0]    acc_sel;
    logic [7:0]    cap_val;

    // last_grant==1 means requester 0 has priority on the next tie
    assign REQ0_READY = (state == S_IDLE) & REQ0_VALID
                      & (~REQ1_VALID | last_grant);
    assign REQ1_READY = (state == S_IDLE) & REQ1_VALID
                      & (~REQ0_VALID | ~last_grant);

    assign BUSY = (state == S_EXEC) | (state == S_RESP);

    always_comb begin
        acc_id  = REQ1_READY;
        acc_d1  = REQ0_DATA1;
        acc_d2  = REQ0_DATA2;
        acc_sel = REQ0_SELECT;
        if (acc_id) begin
            acc_d1  = REQ1_DATA1;
            acc_d2  = REQ1_DATA2;
            acc_sel = REQ1_SELECT;
        end
        // reserved op codes always produce zero
        cap_val = rsvd ? 8'h00 : ALU_RESULT;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= S_IDLE;
            cnt          <= '0;
            gnt          <= 1'b0;
            last_grant   <= 1'b1;
            rsvd         <= 1'b0;
            ALU_DATA1    <= 8'h00;
            ALU_DATA2    <= 8'h00;
            ALU_SELECT   <= 3'b000;
            RESP0_VALID  <= 1'b0;
            RESP1_VALID  <= 1'b0;
            RESP0_RESULT <= 8'h00;
            RESP1_RESULT <= 8'h00;
`ifdef ALU_ARB_ZERO_FLAG_EN
            RESP0_ZERO   <= 1'b0;
            RESP1_ZERO   <= 1'b0;
`endif
        end else begin
            RESP0_VALID <= 1'b0;
            RESP1_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (REQ0_READY | REQ1_READY) begin
                        gnt        <= acc_id;
                        last_grant <= acc_id;
                        ALU_DATA1  <= acc_d1;
                        ALU_DATA2  <= acc_d2;
                        ALU_SELECT <= acc_sel[2] ? 3'b000 : acc_sel;
                        rsvd       <= acc_sel[2];
                        cnt        <= CW'(EXEC_CYCLES - 1);
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        if (gnt) begin
                            RESP1_RESULT <= cap_val;
`ifdef ALU_ARB_ZERO_FLAG_EN
                            RESP1_ZERO   <= (cap_val == 8'h00);
`endif
                        end else begin
                            RESP0_RESULT <= cap_val;
`ifdef ALU_ARB_ZERO_FLAG_EN
                            RESP0_ZERO   <= (cap_val == 8'h00);
`endif
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // pulse appears as the arbiter returns to IDLE
                    RESP0_VALID <= ~gnt;
                    RESP1_VALID <= gnt;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed test of alu_arbiter with a behavioural ALU,
// one instance with EXEC_CYCLES=1 (a_*) and one with EXEC_CYCLES=3 (b_*).
module tb_alu_arbiter;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [2:0] s);
        case (s)
            3'b000:  return a;
            3'b001:  return a + b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    logic       a_v0, a_r0, a_rv0, a_v1, a_r1, a_rv1, a_busy;
    logic [7:0] a_d10, a_d20, a_res0, a_d11, a_d21, a_res1;
    logic [2:0] a_s0, a_s1, a_asel;
    logic [7:0] a_ad1, a_ad2, a_ares;
    logic       b_v0, b_r0, b_rv0, b_v1, b_r1, b_rv1, b_busy;
    logic [7:0] b_d10, b_d20, b_res0, b_d11, b_d21, b_res1;
    logic [2:0] b_s0, b_s1, b_asel;
    logic [7:0] b_ad1, b_ad2, b_ares;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic       a_z0, a_z1, b_z0, b_z1;
`endif

    assign a_ares = alu_f(a_ad1, a_ad2, a_asel);
    assign b_ares = alu_f(b_ad1, b_ad2, b_asel);

    alu_arbiter #(.EXEC_CYCLES(1)) u_a (
        .CLK(clk), .RESET(rst),
        .REQ0_VALID(a_v0), .REQ0_READY(a_r0),
        .REQ0_DATA1(a_d10), .REQ0_DATA2(a_d20), .REQ0_SELECT(a_s0),
        .RESP0_VALID(a_rv0), .RESP0_RESULT(a_res0),
        .REQ1_VALID(a_v1), .REQ1_READY(a_r1),
        .REQ1_DATA1(a_d11), .REQ1_DATA2(a_d21), .REQ1_SELECT(a_s1),
        .RESP1_VALID(a_rv1), .RESP1_RESULT(a_res1),
        .ALU_DATA1(a_ad1), .ALU_DATA2(a_ad2), .ALU_SELECT(a_asel),
        .ALU_RESULT(a_ares),
`ifdef ALU_ARB_ZERO_FLAG_EN
        .RESP0_ZERO(a_z0), .RESP1_ZERO(a_z1),
`endif
        .BUSY(a_busy)
    );

    alu_arbiter #(.EXEC_CYCLES(3)) u_b (
        .CLK(clk), .RESET(rst),
        .REQ0_VALID(b_v0), .REQ0_READY(b_r0),
        .REQ0_DATA1(b_d10), .REQ0_DATA2(b_d20), .REQ0_SELECT(b_s0),
        .RESP0_VALID(b_rv0), .RESP0_RESULT(b_res0),
        .REQ1_VALID(b_v1), .REQ1_READY(b_r1),
        .REQ1_DATA1(b_d11), .REQ1_DATA2(b_d21), .REQ1_SELECT(b_s1),
        .RESP1_VALID(b_rv1), .RESP1_RESULT(b_res1),
        .ALU_DATA1(b_ad1), .ALU_DATA2(b_ad2), .ALU_SELECT(b_asel),
        .ALU_RESULT(b_ares),
`ifdef ALU_ARB_ZERO_FLAG_EN
        .RESP0_ZERO(b_z0), .RESP1_ZERO(b_z1),
`endif
        .BUSY(b_busy)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        a_v0 = 0; a_d10 = 0; a_d20 = 0; a_s0 = 0;
        a_v1 = 0; a_d11 = 0; a_d21 = 0; a_s1 = 0;
        b_v0 = 0; b_d10 = 0; b_d20 = 0; b_s0 = 0;
        b_v1 = 0; b_d11 = 0; b_d21 = 0; b_s1 = 0;
        step();
        step();

        // reset state
        chk("rst_ad1", a_ad1, 8'h00);
        chk("rst_asel", a_asel, 3'b000);
        chk("rst_rv0", a_rv0, 1'b0);
        chk("rst_res0", a_res0, 8'h00);
        chk("rst_busy", a_busy, 1'b0);

        // single add 05+03
        rst = 1'b0;
        a_v0 = 1; a_d10 = 8'h05; a_d20 = 8'h03; a_s0 = 3'b001;
        #1;
        chk("add_rdy0", a_r0, 1'b1);
        chk("add_rdy1", a_r1, 1'b0);
        step();
        a_v0 = 0;
        chk("add_asel", a_asel, 3'b001);
        chk("add_ad1", a_ad1, 8'h05);
        chk("add_busy", a_busy, 1'b1);
        chk("add_rdy_exec", a_r0, 1'b0);
        step();
        chk("add_rv0_early", a_rv0, 1'b0);
        step();
        chk("add_rv0", a_rv0, 1'b1);
        chk("add_res0", a_res0, 8'h08);
        chk("add_rv1", a_rv1, 1'b0);
        chk("add_busy_idle", a_busy, 1'b0);
`ifdef ALU_ARB_ZERO_FLAG_EN
        chk("add_z0", a_z0, 1'b0);
`endif
        step();
        chk("add_rv0_pulse", a_rv0, 1'b0);

        // 8-bit wrap FF+01
        a_v0 = 1; a_d10 = 8'hFF; a_d20 = 8'h01; a_s0 = 3'b001;
        step();
        a_v0 = 0;
        step();
        step();
        chk("wrap_rv0", a_rv0, 1'b1);
        chk("wrap_res0", a_res0, 8'h00);
`ifdef ALU_ARB_ZERO_FLAG_EN
        chk("wrap_z0", a_z0, 1'b1);
`endif
        step();

        // tie from reset: REQ0 and, REQ1 or
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_v0 = 1; a_d10 = 8'hF0; a_d20 = 8'h3C; a_s0 = 3'b010;
        a_v1 = 1; a_d11 = 8'h0F; a_d21 = 8'hA0; a_s1 = 3'b011;
        #1;
        chk("tie_rdy0", a_r0, 1'b1);
        chk("tie_rdy1", a_r1, 1'b0);
        step();
        chk("tie_asel0", a_asel, 3'b010);
        step();
        step();
        chk("tie_rv0", a_rv0, 1'b1);
        chk("tie_res0", a_res0, 8'h30);
        chk("tie_rv1_0", a_rv1, 1'b0);
        chk("tie2_rdy1", a_r1, 1'b1);
        chk("tie2_rdy0", a_r0, 1'b0);
        step();
        chk("tie_asel1", a_asel, 3'b011);
        step();
        step();
        chk("tie_rv1", a_rv1, 1'b1);
        chk("tie_res1", a_res1, 8'hAF);
        chk("tie_res0_hold", a_res0, 8'h30);
        chk("tie3_rdy0", a_r0, 1'b1);
        chk("tie3_rdy1", a_r1, 1'b0);
        step();
        a_v0 = 0;
        a_v1 = 0;
        chk("tie3_asel", a_asel, 3'b010);
        step();
        step();
        chk("tie3_rv0", a_rv0, 1'b1);
        step();

        // reset during EXEC
        a_v0 = 1; a_d10 = 8'hFF; a_d20 = 8'h01; a_s0 = 3'b001;
        step();
        a_v0 = 0;
        chk("mid_busy", a_busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rv0", a_rv0, 1'b0);
        chk("mid_ad1", a_ad1, 8'h00);
        chk("mid_asel", a_asel, 3'b000);
        chk("mid_res1", a_res1, 8'h00);
        chk("mid_busy_rst", a_busy, 1'b0);
        step();
        chk("mid_rv0_after", a_rv0, 1'b0);
        a_v0 = 1; a_v1 = 1;
        #1;
        chk("mid_tie_rdy0", a_r0, 1'b1);
        chk("mid_tie_rdy1", a_r1, 1'b0);
        a_v0 = 0; a_v1 = 0;

        // reserved select 110
        a_v0 = 1; a_d10 = 8'h12; a_d20 = 8'h34; a_s0 = 3'b110;
        step();
        a_v0 = 0;
        chk("rsv_asel", a_asel, 3'b000);
        chk("rsv_ad1", a_ad1, 8'h12);
        step();
        step();
        chk("rsv_rv0", a_rv0, 1'b1);
        chk("rsv_res0", a_res0, 8'h00);
`ifdef ALU_ARB_ZERO_FLAG_EN
        chk("rsv_z0", a_z0, 1'b1);
`endif
        step();

        // EXEC_CYCLES=3: REQ1 forward AA
        b_v1 = 1; b_d11 = 8'hAA; b_d21 = 8'h55; b_s1 = 3'b000;
        #1;
        chk("b_rdy1", b_r1, 1'b1);
        step();
        b_v1 = 0;
        chk("b_busy_0", b_busy, 1'b1);
        chk("b_ad1_0", b_ad1, 8'hAA);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("b_busy", b_busy, 1'b1);
            chk("b_ad1", b_ad1, 8'hAA);
            chk("b_ad2", b_ad2, 8'h55);
            chk("b_asel", b_asel, 3'b000);
            chk("b_rv1_early", b_rv1, 1'b0);
        end
        step();
        chk("b_busy_end", b_busy, 1'b0);
        chk("b_rv1", b_rv1, 1'b1);
        chk("b_res1", b_res1, 8'hAA);
        chk("b_rv0", b_rv0, 1'b0);
        step();
        chk("b_rv1_pulse", b_rv1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer and arbiter that shares the single 8-bit ALU (forward/add/and/or) between two requesters, e.g. the register-file datapath and a branch/address unit.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand and select lines from held registers.
- Waits a fixed number of settle cycles, then returns the registered result to the granted requester as a one-cycle response pulse.
- Round-robin grant on contention.

Parameters:
- EXEC_CYCLES, 1, number of clock cycles ALU inputs are held before RESULT is sampled. Minimum 1; the sampled point must cover the worst ALU delay (add, #2) at the target clock period.

Ports:
- CLK  input  1  system clock, posedge
- RESET  input  1  synchronous, active-high reset
- REQ0_VALID  input  1  requester 0 has an operation pending
- REQ0_READY  output  1  requester 0 operation accepted this edge
- REQ0_DATA1  input  8  requester 0 operand 1
- REQ0_DATA2  input  8  requester 0 operand 2
- REQ0_SELECT  input  3  requester 0 op code: 000 fwd, 001 add, 010 and, 011 or
- RESP0_VALID  output  1  one-cycle pulse, RESP0_RESULT valid
- RESP0_RESULT  output  8  result for requester 0
- REQ1_VALID, REQ1_READY, REQ1_DATA1, REQ1_DATA2, REQ1_SELECT, RESP1_VALID, RESP1_RESULT: same as requester 0
- ALU_DATA1  output  8  to ALU DATA1
- ALU_DATA2  output  8  to ALU DATA2
- ALU_SELECT  output  3  to ALU SELECT
- ALU_RESULT  input  8  from ALU RESULT
- BUSY  output  1  high in EXEC or RESP

Behaviour:
- States:
  - IDLE, EXEC, RESP. Reset state IDLE.
- Reset values (synchronous on RESET=1 at posedge):
  - ALU_DATA1/ALU_DATA2 = 8'h00, ALU_SELECT = 3'b000.
  - RESP*_RESULT = 8'h00, RESP*_VALID = 0.
  - BUSY = 0, cycle counter = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- READY (combinational, IDLE only):
  - REQ0_READY = IDLE & REQ0_VALID & (!REQ1_VALID | last_grant==1).
  - REQ1_READY = IDLE & REQ1_VALID & (!REQ0_VALID | last_grant==0).
  - Never both high. Both low outside IDLE.
- Accept (posedge with VALID&READY):
  - Latch DATA1/DATA2/SELECT into the ALU_* output registers.
  - Record grant id and set last_grant = grant id.
  - Load counter = EXEC_CYCLES-1. Go to EXEC.
- EXEC:
  - ALU_* held stable.
  - If counter != 0: decrement.
  - If counter == 0: capture ALU_RESULT into RESPg_RESULT and go to RESP.
- RESP:
  - RESPg_VALID = 1 for exactly one cycle; other RESP_VALID stays 0. Next state IDLE.
  - RESP*_RESULT holds its value until that requester's next response.
- Latency and throughput:
  - Accept edge to RESP_VALID high: EXEC_CYCLES+1 cycles.
  - Back-to-back issue: one op per EXEC_CYCLES+2 cycles.
  - No new accept is possible in RESP.
- ALU_* outputs hold their last issued values in IDLE and RESP (no toggling).
- Reserved SELECT 100-111:
  - Accepted normally; ALU_SELECT driven 000.
  - Captured result forced to 8'h00.
  - Same latency as a legal op.
- Requester rules:
  - Hold VALID, DATA and SELECT stable until READY.
  - Dropping VALID before READY withdraws the request; no response is produced.
- Same-cycle events:
  - A request arriving in the same cycle as RESP is evaluated in the following IDLE cycle.
  - Continuous requests from both sides alternate grants 0,1,0,1.
- RESET mid-operation (EXEC or RESP):
  - In-flight op abandoned; no RESP_VALID issued.
  - All registers return to reset values on that edge.

Optional Feature:
- Macro: ALU_ARB_ZERO_FLAG_EN.
- With the macro defined:
  - Adds outputs RESP0_ZERO and RESP1_ZERO (1 bit each).
  - Each is registered as (ALU_RESULT==8'h00) on the same edge its result is captured, and held alongside RESP*_RESULT.
  - Reset value 0. Reserved SELECT sets the flag to 1.
- Without the macro: those ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then REQ0 add 8'h05+8'h03, EXEC_CYCLES=1 -> REQ0_READY high at the IDLE edge; ALU_SELECT=001; RESP0_VALID pulses 2 cycles later with RESP0_RESULT=8'h08; RESP1_VALID stays 0.
- REQ0 and REQ1 both valid from reset (REQ0 and 8'hF0&8'h3C, REQ1 or 8'h0F|8'hA0), held -> REQ0 granted first (8'h30), then REQ1 (8'hAF); a further tie grants REQ0.
- REQ1 forward 8'hAA with EXEC_CYCLES=3 -> BUSY high 4 cycles; RESP1_VALID 4 cycles after accept; RESP1_RESULT=8'hAA; ALU_* stable throughout EXEC.
- REQ0 SELECT=3'b110 -> ALU_SELECT=000; RESP0_RESULT=8'h00 after normal latency; RESP0_ZERO=1 with ALU_ARB_ZERO_FLAG_EN.
- Accept REQ0 add 8'hFF+8'h01, assert RESET during EXEC -> no RESP0_VALID; all outputs at reset values next cycle; the next tie grants REQ0.
- Add 8'hFF+8'h01 to completion -> RESP0_RESULT=8'h00 (8-bit wrap); RESP0_ZERO=1 if enabled.
